// File: rtl/nes_pkg.sv
// Shared types and widths for the memory-access stage.
package nes_pkg;

  localparam int unsigned MEM_ADDR_W = 16;
  localparam int unsigned MEM_DATA_W = 8;

  typedef enum logic [1:0] {
    MEM_NONE = 2'd0,
    LOAD8    = 2'd1,
    STORE8   = 2'd2,
    LOAD16   = 2'd3
  } mem_op_t;

  typedef enum logic [2:0] {
    WB_NONE = 3'd0,
    WB_A    = 3'd1,
    WB_X    = 3'd2,
    WB_Y    = 3'd3,
    WB_SP   = 3'd4,
    WB_PC   = 3'd5
  } wb_reg_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ_LO  = 3'd1,
    WAIT_LO = 3'd2,
    REQ_HI  = 3'd3,
    WAIT_HI = 3'd4,
    WB      = 3'd5
  } mem_state_t;

endpackage

// File: rtl/mem_stage.sv
// Memory-access stage: byte-wide little-endian loads/stores and register writeback.
module mem_stage
  import nes_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned DATA_W = MEM_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic [ADDR_W-1:0] alu_res_i,
  input  logic [DATA_W-1:0] st_data_i,
  input  mem_op_t           mem_op_i,
  input  logic              page_wrap_i,
  input  wb_reg_t           wb_reg_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output wb_reg_t           wb_reg_o,
  output logic [ADDR_W-1:0] wb_data_o
);

  mem_state_t        state_q, state_d;
  mem_op_t           op_q, op_d;
  logic              wrap_q, wrap_d;
  logic              rdy_q, rdy_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              valid_q, valid_d;
  wb_reg_t           wb_reg_q, wb_reg_d;
  logic [ADDR_W-1:0] wb_data_q, wb_data_d;
  logic [ADDR_W-1:0] hi_addr;

  // Second byte address; page wrap keeps the high byte of the address fixed.
  assign hi_addr = wrap_q ? {addr_q[ADDR_W-1:DATA_W], addr_q[DATA_W-1:0] + DATA_W'(1)}
                          : addr_q + ADDR_W'(1);

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    wrap_d    = wrap_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    lo_d      = lo_q;
    valid_d   = valid_q;
    wb_reg_d  = wb_reg_q;
    wb_data_d = wb_data_q;

    case (state_q)
      IDLE: begin
        if (ex_valid_i && rdy_q) begin
          op_d     = mem_op_i;
          wrap_d   = page_wrap_i;
          wdata_d  = st_data_i;
          wb_reg_d = (mem_op_i == STORE8) ? WB_NONE : wb_reg_i;
          if (mem_op_i == MEM_NONE) begin
            wb_data_d = alu_res_i;
            valid_d   = 1'b1;
            state_d   = WB;
          end else begin
            addr_d  = alu_res_i;
            req_d   = 1'b1;
            we_d    = (mem_op_i == STORE8);
            state_d = REQ_LO;
          end
        end
      end
      REQ_LO: begin
        if (mem_gnt_i) begin
          req_d = 1'b0;
          we_d  = 1'b0;
          if (op_q == STORE8) begin
            valid_d = 1'b1;
            state_d = WB;
          end else begin
            state_d = WAIT_LO;
          end
        end
      end
      WAIT_LO: begin
        if (mem_rvalid_i) begin
          lo_d = mem_rdata_i;
          if (op_q == LOAD16) begin
            addr_d  = hi_addr;
            req_d   = 1'b1;
            state_d = REQ_HI;
          end else begin
            wb_data_d = ADDR_W'(mem_rdata_i);
            valid_d   = 1'b1;
            state_d   = WB;
          end
        end
      end
      REQ_HI: begin
        if (mem_gnt_i) begin
          req_d   = 1'b0;
          state_d = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (mem_rvalid_i) begin
          wb_data_d = ADDR_W'({mem_rdata_i, lo_q});
          valid_d   = 1'b1;
          state_d   = WB;
        end
      end
      WB: begin
        if (wb_ready_i) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        we_d    = 1'b0;
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase

    rdy_d = (state_d == IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      op_q      <= MEM_NONE;
      wrap_q    <= 1'b0;
      rdy_q     <= 1'b1;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      lo_q      <= '0;
      valid_q   <= 1'b0;
      wb_reg_q  <= WB_NONE;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wrap_q    <= wrap_d;
      rdy_q     <= rdy_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      lo_q      <= lo_d;
      valid_q   <= valid_d;
      wb_reg_q  <= wb_reg_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign ex_ready_o  = rdy_q;
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign wb_valid_o  = valid_q;
  assign wb_reg_o    = wb_reg_q;
  assign wb_data_o   = wb_data_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;
  import nes_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic [15:0] alu_res_i;
  logic [7:0]  st_data_i;
  mem_op_t     mem_op_i;
  logic        page_wrap_i;
  wb_reg_t     wb_reg_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [15:0] mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [7:0]  mem_rdata_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  wb_reg_t     wb_reg_o;
  logic [15:0] wb_data_o;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_stage dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .ex_valid_i   (ex_valid_i),
    .ex_ready_o   (ex_ready_o),
    .alu_res_i    (alu_res_i),
    .st_data_i    (st_data_i),
    .mem_op_i     (mem_op_i),
    .page_wrap_i  (page_wrap_i),
    .wb_reg_i     (wb_reg_i),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .wb_valid_o   (wb_valid_o),
    .wb_ready_i   (wb_ready_i),
    .wb_reg_o     (wb_reg_o),
    .wb_data_o    (wb_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  // Present one operation for a single accept edge.
  task automatic issue(input mem_op_t op, input logic [15:0] res, input logic [7:0] sd,
                       input logic wrap, input wb_reg_t r);
    ex_valid_i  = 1'b1;
    mem_op_i    = op;
    alu_res_i   = res;
    st_data_i   = sd;
    page_wrap_i = wrap;
    wb_reg_i    = r;
    tick();
    ex_valid_i  = 1'b0;
  endtask

  task automatic grant();
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
  endtask

  task automatic rdata(input logic [7:0] d);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = d;
    tick();
    mem_rvalid_i = 1'b0;
  endtask

  task automatic handshake();
    wb_ready_i = 1'b1;
    tick();
    wb_ready_i = 1'b0;
    check("idle_after_wb", 16'({ex_ready_o, wb_valid_o}), 16'b10);
  endtask

  // Zero-wait LOAD16 of 16'h1234 checking both bus addresses.
  task automatic load16(input string tag, input logic [15:0] a, input logic wrap,
                        input logic [15:0] hi);
    issue(LOAD16, a, 8'h00, wrap, WB_PC);
    check({tag, "_lo_addr"}, mem_addr_o, a);
    check({tag, "_lo_req"}, 16'({mem_req_o, mem_we_o}), 16'b10);
    grant();
    rdata(8'h34);
    check({tag, "_hi_addr"}, mem_addr_o, hi);
    check({tag, "_hi_req"}, 16'({mem_req_o, mem_we_o, wb_valid_o}), 16'b100);
    grant();
    rdata(8'h12);
    check({tag, "_valid"}, 16'(wb_valid_o), 16'd1);
    check({tag, "_data"}, wb_data_o, 16'h1234);
    check({tag, "_reg"}, 16'(wb_reg_o), 16'(WB_PC));
    handshake();
  endtask

  initial begin
    rst_i = 1'b1; ex_valid_i = 1'b0; alu_res_i = '0; st_data_i = '0;
    mem_op_i = MEM_NONE; page_wrap_i = 1'b0; wb_reg_i = WB_NONE;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; wb_ready_i = 1'b0;
    tick(); tick();

    // Reset values
    check("rst_ex_ready", 16'(ex_ready_o), 16'd1);
    check("rst_req_we_valid", 16'({mem_req_o, mem_we_o, wb_valid_o}), 16'b000);
    check("rst_addr", mem_addr_o, 16'h0000);
    check("rst_wdata", 16'(mem_wdata_o), 16'h0000);
    check("rst_wb_data", wb_data_o, 16'h0000);
    check("rst_wb_reg", 16'(wb_reg_o), 16'(WB_NONE));
    rst_i = 1'b0;

    // MEM_NONE with 4 cycles of writeback backpressure; a pending LOAD8 must wait
    issue(MEM_NONE, 16'h1234, 8'h00, 1'b0, WB_X);
    check("none_valid_t1", 16'(wb_valid_o), 16'd1);
    check("none_data", wb_data_o, 16'h1234);
    check("none_reg", 16'(wb_reg_o), 16'(WB_X));
    ex_valid_i = 1'b1; mem_op_i = LOAD8; alu_res_i = 16'hBEEF; wb_reg_i = WB_Y;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_valid", 16'(wb_valid_o), 16'd1);
      check("bp_data", wb_data_o, 16'h1234);
      check("bp_reg", 16'(wb_reg_o), 16'(WB_X));
      check("bp_ready_req", 16'({ex_ready_o, mem_req_o}), 16'b00);
    end
    ex_valid_i = 1'b0;
    handshake();
    check("bp_no_req_after", 16'(mem_req_o), 16'd0);

    // LOAD8 from 16'h00FF with grant delayed 3 cycles
    issue(LOAD8, 16'h00FF, 8'h00, 1'b0, WB_A);
    check("ld8_req", 16'({mem_req_o, mem_we_o}), 16'b10);
    check("ld8_addr0", mem_addr_o, 16'h00FF);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ld8_req_held", 16'(mem_req_o), 16'd1);
      check("ld8_addr_held", mem_addr_o, 16'h00FF);
    end
    grant();
    check("ld8_req_drop", 16'({mem_req_o, wb_valid_o}), 16'b00);
    rdata(8'hA5);
    check("ld8_valid", 16'(wb_valid_o), 16'd1);
    check("ld8_data", wb_data_o, 16'h00A5);
    check("ld8_reg", 16'(wb_reg_o), 16'(WB_A));
    handshake();

    // LOAD16 second-address variants
    load16("ld16_wrap", 16'h02FF, 1'b1, 16'h0200);
    load16("ld16_nowrap", 16'h02FF, 1'b0, 16'h0300);
    load16("ld16_top", 16'hFFFF, 1'b0, 16'h0000);

    // STORE8 to 16'h4016
    issue(STORE8, 16'h4016, 8'h5A, 1'b0, WB_A);
    check("st_req_we", 16'({mem_req_o, mem_we_o}), 16'b11);
    check("st_addr", mem_addr_o, 16'h4016);
    check("st_wdata", 16'(mem_wdata_o), 16'h005A);
    check("st_ex_ready", 16'(ex_ready_o), 16'd0);
    grant();
    check("st_one_req", 16'({mem_req_o, mem_we_o}), 16'b00);
    check("st_valid", 16'(wb_valid_o), 16'd1);
    check("st_reg_none", 16'(wb_reg_o), 16'(WB_NONE));
    check("st_ex_ready_wb", 16'(ex_ready_o), 16'd0);
    handshake();

    // Reset during REQ_LO, then again during WAIT_LO, with a stray rvalid afterwards
    issue(LOAD8, 16'h0010, 8'h00, 1'b0, WB_A);
    check("abort_req_pending", 16'(mem_req_o), 16'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("abort_req_drop", 16'({ex_ready_o, mem_req_o, wb_valid_o}), 16'b100);
    issue(LOAD8, 16'h0020, 8'h00, 1'b0, WB_A);
    grant();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("abort2_idle", 16'({ex_ready_o, mem_req_o, wb_valid_o}), 16'b100);
    rdata(8'h77);
    tick();
    check("abort2_stray_rvalid", 16'({ex_ready_o, wb_valid_o}), 16'b10);
    check("abort2_wb_data", wb_data_o, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
